// File: rtl/distram_fifo_sync_fwft_if.sv
// Write/read handshake, status flags and threshold bundle for distram_fifo_sync_fwft.
// The FIFO takes the slave side; the producer/consumer logic takes the master side.
interface distram_fifo_sync_fwft_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 6
);
    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   rd_en;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   valid;
    logic                   wr_ack;
    logic                   overflow;
    logic                   underflow;
    logic                   full;
    logic                   empty;
    logic                   almost_full;
    logic                   almost_empty;
    logic [COUNT_WIDTH-1:0] prog_full_thresh;
    logic [COUNT_WIDTH-1:0] prog_empty_thresh;
    logic                   prog_full;
    logic                   prog_empty;
    logic [COUNT_WIDTH-1:0] count;

    modport master (
        output wr_en, wr_data, rd_en, prog_full_thresh, prog_empty_thresh,
        input  rd_data, valid, wr_ack, overflow, underflow, full, empty,
               almost_full, almost_empty, prog_full, prog_empty, count
    );

    modport slave (
        input  wr_en, wr_data, rd_en, prog_full_thresh, prog_empty_thresh,
        output rd_data, valid, wr_ack, overflow, underflow, full, empty,
               almost_full, almost_empty, prog_full, prog_empty, count
    );
endinterface

// File: rtl/distram_fifo_sync_fwft.sv
// Single-clock FIFO on distributed dual-port RAM with a registered read port,
// selectable standard (1-cycle latency) or first-word-fall-through read mode.
module distram_fifo_sync_fwft #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 32,
    parameter bit FWFT        = 1'b0,
    parameter int ADDR_WIDTH  = $clog2(FIFO_DEPTH),
    parameter int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    distram_fifo_sync_fwft_if.slave bus
);
    localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(FIFO_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]  PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0]  dout;
    logic                   dvalid;
    logic                   wr_ack_q;
    logic                   overflow_q;
    logic                   underflow_q;
    logic                   full_c;
    logic                   empty_c;
    logic                   wa;
    logic                   ra;
    logic                   load;

    assign full_c  = (count_q == DEPTH_C);
    assign empty_c = FWFT ? ~dvalid : (count_q == '0);
    assign wa      = bus.wr_en & ~full_c;
    assign ra      = bus.rd_en & ~empty_c;

    // In FWFT mode count includes the output register, so RAM occupancy is count - dvalid.
    generate
        if (FWFT) begin : g_fwft
            logic [COUNT_WIDTH-1:0] ram_count;
            assign ram_count = count_q - COUNT_WIDTH'(dvalid);
            assign load      = (~dvalid | ra) & (ram_count != '0);
        end else begin : g_std
            assign load = ra;
        end
    endgenerate

    // NOTE: the storage array has no reset so it maps onto LUT RAM; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wa) mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            dout        <= '0;
            dvalid      <= 1'b0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wa) wr_ptr <= wr_ptr + PTR_ONE;
            if (load) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // Standard mode: one-cycle valid pulse. FWFT mode: output register occupancy.
            dvalid <= FWFT ? (load | (dvalid & ~ra)) : ra;
            case ({wa, ra})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            wr_ack_q    <= wa;
            overflow_q  <= bus.wr_en & full_c;
            underflow_q <= bus.rd_en & empty_c;
        end
    end

    assign bus.rd_data      = dout;
    assign bus.valid        = dvalid;
    assign bus.wr_ack       = wr_ack_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= DEPTH_C - CNT_ONE);
    assign bus.almost_empty = (count_q <= CNT_ONE);
    assign bus.prog_full    = (count_q >= bus.prog_full_thresh);
    assign bus.prog_empty   = (count_q <= bus.prog_empty_thresh);
    assign bus.count        = count_q;
endmodule

// File: tb/tb_distram_fifo_sync_fwft.sv
// Standard and FWFT instances run side by side, each tracked by its own queue model
// that predicts acceptance, occupancy, flags and read data cycle by cycle.
module tb_distram_fifo_sync_fwft;
    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DW-1:0] rd_data;
        logic          valid;
        logic          wr_ack;
        logic          overflow;
        logic          underflow;
        logic          full;
        logic          empty;
        logic          almost_full;
        logic          almost_empty;
        logic          prog_full;
        logic          prog_empty;
        logic [CW-1:0] count;
    } out_t;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        int            cnt;
        logic          full;
        logic          afull;
        logic          pfull;
        logic          ack;
        logic          ovf;
    } vec_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [CW-1:0] pf_th = CW'(24);
    logic [CW-1:0] pe_th = CW'(4);

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] sb_s[$];
    logic [DW-1:0] sb_f[$];
    int            occ_s, occ_f, rx_s, rx_f;
    logic          mdv;
    logic [DW-1:0] last_s;

    vec_t vecs[33];
    out_t o;
    int   next_s, next_f;
    logic ws, wf, rs, rf;

    always #5 clk = ~clk;

    distram_fifo_sync_fwft_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus_s ();
    distram_fifo_sync_fwft_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus_f ();

    assign bus_s.prog_full_thresh  = pf_th;
    assign bus_s.prog_empty_thresh = pe_th;
    assign bus_f.prog_full_thresh  = pf_th;
    assign bus_f.prog_empty_thresh = pe_th;

    distram_fifo_sync_fwft #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1'b0)) u_std (
        .clk(clk), .rst_n(rst_n), .bus(bus_s)
    );
    distram_fifo_sync_fwft #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .bus(bus_f)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic out_t sample(input bit fwft);
        out_t r;
        if (fwft)
            r = {bus_f.rd_data, bus_f.valid, bus_f.wr_ack, bus_f.overflow, bus_f.underflow,
                 bus_f.full, bus_f.empty, bus_f.almost_full, bus_f.almost_empty,
                 bus_f.prog_full, bus_f.prog_empty, bus_f.count};
        else
            r = {bus_s.rd_data, bus_s.valid, bus_s.wr_ack, bus_s.overflow, bus_s.underflow,
                 bus_s.full, bus_s.empty, bus_s.almost_full, bus_s.almost_empty,
                 bus_s.prog_full, bus_s.prog_empty, bus_s.count};
        return r;
    endfunction

    function automatic out_t flags(input int occ);
        out_t e;
        e              = '0;
        e.count        = CW'(occ);
        e.full         = (occ == DEPTH);
        e.almost_full  = (occ >= DEPTH - 1);
        e.almost_empty = (occ <= 1);
        e.prog_full    = (occ >= int'(pf_th));
        e.prog_empty   = (occ <= int'(pe_th));
        return e;
    endfunction

    task automatic cmp(input string tag, input out_t a, input out_t e, input bit chk_data);
        if (chk_data) check({tag, " rd_data"}, 64'(a.rd_data), 64'(e.rd_data));
        check({tag, " valid"},        64'(a.valid),        64'(e.valid));
        check({tag, " wr_ack"},       64'(a.wr_ack),       64'(e.wr_ack));
        check({tag, " overflow"},     64'(a.overflow),     64'(e.overflow));
        check({tag, " underflow"},    64'(a.underflow),    64'(e.underflow));
        check({tag, " full"},         64'(a.full),         64'(e.full));
        check({tag, " empty"},        64'(a.empty),        64'(e.empty));
        check({tag, " almost_full"},  64'(a.almost_full),  64'(e.almost_full));
        check({tag, " almost_empty"}, 64'(a.almost_empty), 64'(e.almost_empty));
        check({tag, " prog_full"},    64'(a.prog_full),    64'(e.prog_full));
        check({tag, " prog_empty"},   64'(a.prog_empty),   64'(e.prog_empty));
        check({tag, " count"},        64'(a.count),        64'(e.count));
    endtask

    task automatic drive_idle();
        bus_s.wr_en = 1'b0; bus_s.rd_en = 1'b0; bus_s.wr_data = '0;
        bus_f.wr_en = 1'b0; bus_f.rd_en = 1'b0; bus_f.wr_data = '0;
    endtask

    // Drive one cycle on each instance, advance the models, then compare every output.
    task automatic step(input logic w_s, input logic r_s, input logic [DW-1:0] d_s,
                        input logic w_f, input logic r_f, input logic [DW-1:0] d_f);
        logic s_wa, s_ra, f_wa, f_ra, f_load;
        out_t e;
        bus_s.wr_en = w_s; bus_s.rd_en = r_s; bus_s.wr_data = d_s;
        bus_f.wr_en = w_f; bus_f.rd_en = r_f; bus_f.wr_data = d_f;
        s_wa   = w_s && (occ_s != DEPTH);
        s_ra   = r_s && (occ_s != 0);
        f_wa   = w_f && (occ_f != DEPTH);
        f_ra   = r_f && mdv;
        f_load = (!mdv || f_ra) && ((occ_f - (mdv ? 1 : 0)) > 0);
        if (s_wa) sb_s.push_back(d_s);
        if (f_wa) sb_f.push_back(d_f);
        if (s_ra && sb_s.size() > 0) begin last_s = sb_s.pop_front(); rx_s++; end
        if (f_ra && sb_f.size() > 0) begin void'(sb_f.pop_front()); rx_f++; end
        @(posedge clk);
        #1;
        occ_s = occ_s + int'(s_wa) - int'(s_ra);
        occ_f = occ_f + int'(f_wa) - int'(f_ra);
        mdv   = f_load || (mdv && !f_ra);

        e           = flags(occ_s);
        e.empty     = (occ_s == 0);
        e.valid     = s_ra;
        e.rd_data   = last_s;
        e.wr_ack    = s_wa;
        e.overflow  = w_s && !s_wa;
        e.underflow = r_s && !s_ra;
        cmp("std", sample(1'b0), e, 1'b1);

        e           = flags(occ_f);
        e.empty     = !mdv;
        e.valid     = mdv;
        e.rd_data   = (sb_f.size() > 0) ? sb_f[0] : '0;
        e.wr_ack    = f_wa;
        e.overflow  = w_f && !f_wa;
        e.underflow = r_f && !f_ra;
        cmp("fwft", sample(1'b1), e, mdv);
    endtask

    task automatic step2(input logic w, input logic r, input logic [DW-1:0] d);
        step(w, r, d, w, r, d);
    endtask

    task automatic do_reset(input string tag);
        out_t e;
        drive_idle();
        rst_n = 1'b0;
        #1;
        e       = flags(0);
        e.empty = 1'b1;
        cmp({tag, " std"},  sample(1'b0), e, 1'b1);
        cmp({tag, " fwft"}, sample(1'b1), e, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb_s.delete(); sb_f.delete();
        occ_s = 0; occ_f = 0; rx_s = 0; rx_f = 0;
        mdv = 1'b0; last_s = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 33; i++) begin
            vecs[i].wr    = 1'b1;
            vecs[i].rd    = 1'b0;
            vecs[i].din   = DW'(i);
            vecs[i].cnt   = (i < DEPTH) ? i + 1 : DEPTH;
            vecs[i].full  = (vecs[i].cnt == DEPTH);
            vecs[i].afull = (vecs[i].cnt >= DEPTH - 1);
            vecs[i].pfull = (vecs[i].cnt >= 24);
            vecs[i].ack   = (i < DEPTH);
            vecs[i].ovf   = (i >= DEPTH);
        end

        drive_idle();
        #2;
        do_reset("reset");

        // Fill 33 words into a 32-deep FIFO, last one must overflow.
        for (int i = 0; i < 33; i++) begin
            step2(vecs[i].wr, vecs[i].rd, vecs[i].din);
            o = sample(1'b0);
            check($sformatf("fill[%0d] count", i),     64'(o.count),       64'(vecs[i].cnt));
            check($sformatf("fill[%0d] full", i),      64'(o.full),        64'(vecs[i].full));
            check($sformatf("fill[%0d] almost_full", i), 64'(o.almost_full), 64'(vecs[i].afull));
            check($sformatf("fill[%0d] prog_full", i), 64'(o.prog_full),   64'(vecs[i].pfull));
            check($sformatf("fill[%0d] wr_ack", i),    64'(o.wr_ack),      64'(vecs[i].ack));
            check($sformatf("fill[%0d] overflow", i),  64'(o.overflow),    64'(vecs[i].ovf));
        end
        step2(1'b0, 1'b0, '0);
        check("overflow single pulse", 64'(bus_s.overflow), 64'(0));

        // Drain all words, then one read past empty.
        for (int i = 0; i < DEPTH; i++) begin
            step2(1'b0, 1'b1, '0);
            check($sformatf("drain[%0d] data", i), 64'(bus_s.rd_data), 64'(i));
        end
        check("drain empty", 64'(bus_s.empty), 64'(1));
        step2(1'b0, 1'b1, '0);
        check("underflow pulse", 64'(bus_s.underflow), 64'(1));
        check("underflow valid", 64'(bus_s.valid), 64'(0));
        check("underflow hold", 64'(bus_s.rd_data), 64'(8'h1F));
        step2(1'b0, 1'b0, '0);

        // FWFT first-word latency.
        do_reset("reset fwft");
        step2(1'b1, 1'b0, 8'hA5);
        check("fwft N count", 64'(bus_f.count), 64'(1));
        step2(1'b0, 1'b0, '0);
        check("fwft N+1 data", 64'(bus_f.rd_data), 64'(8'hA5));
        check("fwft N+1 valid", 64'(bus_f.valid), 64'(1));
        check("fwft N+1 empty", 64'(bus_f.empty), 64'(0));
        step2(1'b0, 1'b1, '0);
        check("fwft read empty", 64'(bus_f.empty), 64'(1));
        check("fwft read count", 64'(bus_f.count), 64'(0));

        // Simultaneous read and write at count 5, 32 and 0.
        do_reset("reset sim");
        for (int i = 0; i < 5; i++) step2(1'b1, 1'b0, DW'(8'h10 + i));
        step2(1'b0, 1'b0, '0);
        step2(1'b1, 1'b1, 8'h15);
        check("rw@5 std count", 64'(bus_s.count), 64'(5));
        check("rw@5 fwft count", 64'(bus_f.count), 64'(5));
        check("rw@5 std data", 64'(bus_s.rd_data), 64'(8'h10));
        repeat (6) step2(1'b0, 1'b1, '0);
        for (int i = 0; i < DEPTH; i++) step2(1'b1, 1'b0, DW'(i + 8'h80));
        step2(1'b0, 1'b0, '0);
        step2(1'b1, 1'b1, 8'hEE);
        check("rw@32 std count", 64'(bus_s.count), 64'(31));
        check("rw@32 std overflow", 64'(bus_s.overflow), 64'(1));
        check("rw@32 fwft count", 64'(bus_f.count), 64'(31));
        repeat (DEPTH) step2(1'b0, 1'b1, '0);
        step2(1'b1, 1'b1, 8'h77);
        check("rw@0 std count", 64'(bus_s.count), 64'(1));
        check("rw@0 std underflow", 64'(bus_s.underflow), 64'(1));
        check("rw@0 fwft count", 64'(bus_f.count), 64'(1));
        step2(1'b0, 1'b0, '0);
        step2(1'b0, 1'b1, '0);
        check("rw@0 std data", 64'(bus_s.rd_data), 64'(8'h77));
        step2(1'b0, 1'b0, '0);

        // 200-word random stream through both modes, wrapping the pointers several times.
        do_reset("reset stream");
        next_s = 0;
        next_f = 0;
        for (int cyc = 0; cyc < 4000 && (rx_s < 200 || rx_f < 200); cyc++) begin
            ws = (next_s < 200) && ($urandom_range(0, 3) != 0);
            wf = (next_f < 200) && ($urandom_range(0, 3) != 0);
            rs = $urandom_range(0, 99) < ((cyc < 300) ? 35 : 75);
            rf = $urandom_range(0, 99) < ((cyc < 300) ? 35 : 75);
            step(ws, rs, DW'(next_s), wf, rf, DW'(next_f));
            if (ws && bus_s.wr_ack) next_s++;
            if (wf && bus_f.wr_ack) next_f++;
        end
        check("stream std words out", 64'(rx_s), 64'(200));
        check("stream fwft words out", 64'(rx_f), 64'(200));

        // Threshold change and mid-operation reset at count 10.
        do_reset("reset thr");
        for (int i = 0; i < 10; i++) step2(1'b1, 1'b0, DW'(8'h40 + i));
        step2(1'b0, 1'b0, '0);
        pf_th = CW'(8);
        #1;
        check("thr 8 std prog_full", 64'(bus_s.prog_full), 64'(1));
        check("thr 8 fwft prog_full", 64'(bus_f.prog_full), 64'(1));
        pf_th = CW'(24);
        #1;
        check("thr 24 std prog_full", 64'(bus_s.prog_full), 64'(0));
        do_reset("reset @10");
        step2(1'b1, 1'b0, 8'h3C);
        step2(1'b0, 1'b0, '0);
        check("post-reset fwft data", 64'(bus_f.rd_data), 64'(8'h3C));
        step2(1'b0, 1'b1, '0);
        check("post-reset std data", 64'(bus_s.rd_data), 64'(8'h3C));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/distram_fifo_sync_fwft.md
Name: distram_fifo_sync_fwft

Overview:
Parametrised synchronous FIFO built on distributed dual-port RAM, for shallow buffering of up to 64 entries between pipeline stages in one clock domain.
Supports two read modes:
- standard: registered output, 1-cycle read latency.
- first-word-fall-through (FWFT): head word presented early, `valid`/`empty` driven from an output register.
Adds handshake/error reporting (wr_ack, valid, overflow, underflow), almost flags and run-time programmable thresholds.

Parameters:
- DATA_WIDTH, 8, word width in bits (1..64).
- FIFO_DEPTH, 32, total capacity in words; power of two, 4..64.
- FWFT, 0, read mode: 0 = standard, 1 = first-word-fall-through.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), RAM address width (derived; do not override).
- COUNT_WIDTH, $clog2(FIFO_DEPTH)+1, width of count and threshold ports.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- rd_en  in  1  read request (FWFT: acknowledges the word on rd_data).
- rd_data  out  DATA_WIDTH  read word (registered in both modes).
- valid  out  1  rd_data holds a valid word.
- wr_ack  out  1  previous-cycle write was accepted.
- overflow  out  1  previous-cycle write was rejected (FIFO full).
- underflow  out  1  previous-cycle read was rejected (FIFO empty).
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  no word available to read.
- almost_full  out  1  count >= FIFO_DEPTH-1.
- almost_empty  out  1  count <= 1.
- prog_full_thresh  in  COUNT_WIDTH  run-time prog_full level.
- prog_empty_thresh  in  COUNT_WIDTH  run-time prog_empty level.
- prog_full  out  1  count >= prog_full_thresh.
- prog_empty  out  1  count <= prog_empty_thresh.
- count  out  COUNT_WIDTH  words held; FWFT count includes the output register.

Behaviour:
Reset:
- Async assert; pointers, count, rd_data, output-register state all 0.
- Outputs after reset: valid=0, wr_ack=0, overflow=0, underflow=0, full=0, empty=1, almost_empty=1, almost_full=0.
- prog_full/prog_empty follow their compare rules on count=0 (prog_empty=1; prog_full=1 only if thresh=0).
- Reset mid-operation discards all contents immediately; no output glitch after release.

Accept rules:
- wa = wr_en & ~full; ra = rd_en & ~empty.
- Both are evaluated on current flags, so full blocks writes even with a simultaneous read, and empty blocks reads even with a simultaneous write.
- Counters are modulo FIFO_DEPTH and wrap naturally.

Count:
- +1 on wa only; -1 on ra only; unchanged on both or neither.
- Never exceeds FIFO_DEPTH; never underflows.

Standard mode (FWFT=0):
- empty = (count==0).
- On ra at edge N: rd_data <= mem[rd_ptr] at edge N; valid=1 for the following cycle only.
- Without ra: rd_data holds its value and valid=0.

FWFT mode (FWFT=1):
- Output register (dout, dvalid) is loaded from RAM whenever dvalid=0, or ra occurs, and RAM occupancy (count - dvalid) > 0.
- If ra occurs and RAM is empty, dvalid clears.
- empty = ~dvalid; valid = dvalid; rd_data = dout.
- First-word latency: write at edge N, word on rd_data with empty=0 after edge N+1.
- A write into empty RAM during ra produces a one-cycle bubble (dvalid=0 for one cycle); accepted.

Status and flags:
- Status flags are combinational from the registered count and state plus the threshold inputs.
- Thresholds are quasi-static; a change takes effect in the same cycle.
- wr_ack, overflow, underflow are registered single-cycle pulses, one cycle after the causing edge.
- overflow = wr_en & full; underflow = rd_en & empty.

Memory and read path:
- Storage: the team's xilinx_dp_distram wrapper, written on wa at wr_ptr; async read port addressed by rd_ptr.
- No combinational path from wr_en or rd_en to rd_data.

Test Plan:
1. FWFT=0, DEPTH=32, thresh 24/4: write 0x00..0x1F back-to-back.
   - wr_ack each cycle.
   - almost_full after 31st write; prog_full after 24th.
   - full and count=32 after 32nd.
   - 33rd write: overflow pulse, wr_ack=0, count stays 32.
2. FWFT=0, drain all 32 words.
   - rd_data = 0x00..0x1F, each one cycle after its rd_en with valid=1.
   - empty after the last read.
   - Further rd_en: underflow pulse, valid=0, rd_data holds 0x1F.
3. FWFT=1, single write of 0xA5 at edge N into empty FIFO.
   - count=1 after N; rd_data=0xA5, valid=1, empty=0 after N+1.
   - rd_en then gives empty=1, count=0.
4. Simultaneous events:
   - Read+write at count=5: count stays 5, order preserved.
   - Read+write at count=32: read accepted, write rejected, overflow=1, count=31.
   - Read+write at count=0: write accepted, underflow=1, count=1.
5. Wrap-around: stream 200 incrementing words with random wr_en/rd_en stalls, in both modes.
   - Output sequence is exact, with no loss or duplication.
   - count always equals scoreboard occupancy.
6. Reset and thresholds:
   - rst_n low at count=10: all outputs at reset values immediately; first post-reset write reads back correctly.
   - Change prog_full_thresh 24→8 at count=10: prog_full rises the same cycle.
